// File: rtl/jtag_tap_driver.sv
// JTAG initiator: walks a 1149.1 TAP through single IR/DR scans and returns
// the captured TDO bits over a valid/ready response channel.
module jtag_tap_driver #(
    parameter int ClkDiv   = 2,
    parameter int MaxLen   = 64,
    parameter int LenWidth = $clog2(MaxLen + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_is_ir_i,
    input  logic [LenWidth-1:0] req_len_i,
    input  logic [MaxLen-1:0]   req_data_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [MaxLen-1:0]   rsp_data_o,
    output logic                jtag_tck_o,
    output logic                jtag_tms_o,
    output logic                jtag_tdi_o,
    output logic                jtag_trst_no,
    input  logic                jtag_tdo_i
);
    localparam int BW = $clog2(MaxLen + 7);
    localparam int KW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
    localparam int CW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [CW-1:0] DivLoad  = CW'(ClkDiv - 1);
    localparam logic [BW-1:0] InitLast = BW'(5);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_SCAN, S_RESP} state_e;

    typedef struct packed {
        logic                is_ir;
        logic [LenWidth-1:0] len;
        logic [MaxLen-1:0]   data;
    } req_t;

    state_e          state;
    req_t            req_q;
    logic            start;
    logic [CW-1:0]   div_cnt;
    logic [BW-1:0]   bit_cnt;

    logic [LenWidth-1:0] len_sat;
    logic [BW-1:0]       pre, shift_end, last_bit, nxt_bit;
    logic [KW-1:0]       nxt_k, cur_k;
    logic                tms_nxt, tdi_nxt, cur_shift;

    // Bit-cycle index layout: preamble (3 DR / 4 IR), shift bits, Exit1->Update, ->Idle.
    always_comb begin
        len_sat   = (req_len_i > LenWidth'(MaxLen)) ? LenWidth'(MaxLen) : req_len_i;
        pre       = req_q.is_ir ? BW'(4) : BW'(3);
        shift_end = pre + BW'(req_q.len);
        last_bit  = (state == S_INIT) ? InitLast : shift_end + BW'(1);
        nxt_bit   = start ? '0 : bit_cnt + BW'(1);
        nxt_k     = KW'(nxt_bit - pre);
        cur_k     = KW'(bit_cnt - pre);
        cur_shift = (state == S_SCAN) && (bit_cnt >= pre) && (bit_cnt < shift_end);
        tms_nxt   = 1'b0;
        tdi_nxt   = 1'b0;
        if (state == S_INIT) begin
            tms_nxt = (nxt_bit != InitLast);
        end else if (nxt_bit < pre) begin
            tms_nxt = (nxt_bit == '0) || (req_q.is_ir && nxt_bit == BW'(1));
        end else if (nxt_bit < shift_end) begin
            tms_nxt = (nxt_bit == shift_end - BW'(1));
            tdi_nxt = req_q.data[nxt_k];
        end else begin
            tms_nxt = (nxt_bit == shift_end);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_INIT;
            start        <= 1'b1;
            req_q        <= '0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            jtag_tck_o   <= 1'b0;
            jtag_tms_o   <= 1'b1;
            jtag_tdi_o   <= 1'b0;
            jtag_trst_no <= 1'b0;
            req_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_data_o   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        req_q.is_ir <= req_is_ir_i;
                        req_q.len   <= len_sat;
                        req_q.data  <= req_data_i;
                        rsp_data_o  <= '0;
                        start       <= 1'b1;
                        state       <= S_SCAN;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    // INIT and SCAN share the bit-cycle engine
                    jtag_trst_no <= 1'b1;
                    if (start) begin
                        start <= 1'b0;
                        if (state == S_SCAN && req_q.len == '0) begin
                            rsp_valid_o <= 1'b1;
                            state       <= S_RESP;
                        end else begin
                            bit_cnt    <= '0;
                            jtag_tms_o <= tms_nxt;
                            jtag_tdi_o <= tdi_nxt;
                            div_cnt    <= DivLoad;
                        end
                    end else if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else if (!jtag_tck_o) begin
                        jtag_tck_o <= 1'b1;
                        div_cnt    <= DivLoad;
                        if (cur_shift) rsp_data_o[cur_k] <= jtag_tdo_i;
                    end else begin
                        jtag_tck_o <= 1'b0;
                        if (bit_cnt == last_bit) begin
                            jtag_tdi_o <= 1'b0;
                            if (state == S_INIT) begin
                                req_ready_o <= 1'b1;
                                state       <= S_IDLE;
                            end else begin
                                rsp_valid_o <= 1'b1;
                                state       <= S_RESP;
                            end
                        end else begin
                            bit_cnt    <= nxt_bit;
                            jtag_tms_o <= tms_nxt;
                            jtag_tdi_o <= tdi_nxt;
                            div_cnt    <= DivLoad;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_tap_driver.sv
// Bench for jtag_tap_driver: behavioural TAP target, response scoreboard with
// an independent monitor, and directed scans with hand-computed results.
module tb_jtag_tap_driver;
    localparam int ClkDiv = 2;
    localparam int MaxLen = 64;
    localparam int LW     = $clog2(MaxLen + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic              req_valid = 1'b0, req_is_ir = 1'b0, rsp_ready = 1'b1;
    logic [LW-1:0]     req_len = '0;
    logic [MaxLen-1:0] req_data = '0;
    logic              req_ready, rsp_valid;
    logic [MaxLen-1:0] rsp_data;
    logic              tck, tms, tdi, trst_n, tdo;

    jtag_tap_driver #(.ClkDiv(ClkDiv), .MaxLen(MaxLen)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_is_ir_i(req_is_ir),
        .req_len_i(req_len), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_tdi_o(tdi),
        .jtag_trst_no(trst_n), .jtag_tdo_i(tdo)
    );

    // Behavioural TAP target: 8-bit DR, 5-bit IR capturing 5'b00001
    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                              SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_e;
    tap_e       ts = TLR;
    logic [7:0] dr_cap = 8'h3C;
    logic [7:0] dr_sr = '0, dr_reg = '0;
    logic [4:0] ir_sr = '0, ir_reg = '0;
    int         dr_shifts = 0;
    logic       tdo_r = 1'b0;
    assign tdo = tdo_r;

    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ts <= TLR;
        end else begin
            case (ts)
                CAPDR: dr_sr <= dr_cap;
                SHDR:  begin dr_sr <= {tdi, dr_sr[7:1]}; dr_shifts <= dr_shifts + 1; end
                UPDR:  dr_reg <= dr_sr;
                CAPIR: ir_sr <= 5'h01;
                SHIR:  ir_sr <= {tdi, ir_sr[4:1]};
                UPIR:  ir_reg <= ir_sr;
                default: ;
            endcase
            case (ts)
                TLR:   ts <= tms ? TLR   : RTI;
                RTI:   ts <= tms ? SELDR : RTI;
                SELDR: ts <= tms ? SELIR : CAPDR;
                CAPDR: ts <= tms ? EX1DR : SHDR;
                SHDR:  ts <= tms ? EX1DR : SHDR;
                EX1DR: ts <= tms ? UPDR  : PADR;
                PADR:  ts <= tms ? EX2DR : PADR;
                EX2DR: ts <= tms ? UPDR  : SHDR;
                UPDR:  ts <= tms ? SELDR : RTI;
                SELIR: ts <= tms ? TLR   : CAPIR;
                CAPIR: ts <= tms ? EX1IR : SHIR;
                SHIR:  ts <= tms ? EX1IR : SHIR;
                EX1IR: ts <= tms ? UPIR  : PAIR;
                PAIR:  ts <= tms ? EX2IR : PAIR;
                EX2IR: ts <= tms ? UPIR  : SHIR;
                default: ts <= tms ? SELDR : RTI;
            endcase
        end
    end

    always @(negedge tck) tdo_r <= (ts == SHDR) ? dr_sr[0] : (ts == SHIR) ? ir_sr[0] : 1'b0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // TCK rise logger: pulse count, TMS history (first pulse ends up most significant)
    int          pulses = 0;
    int          rise_at[1024];
    logic [63:0] tms_hist = '0;
    logic        tck_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (tck && !tck_prev) begin
            if (pulses < 1024) rise_at[pulses] = cyc;
            tms_hist = {tms_hist[62:0], tms};
            pulses++;
        end
        tck_prev = tck;
    end

    // Scoreboard: stimulus pushes, monitor reads in order
    typedef struct {
        logic [63:0] data;
        int          rise;
    } exp_t;
    exp_t sb[$];
    int   rd_idx = 0;
    logic vprev = 1'b0;

    initial forever begin
        @(negedge clk);
        if (rsp_valid) begin
            if (rd_idx >= sb.size()) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got data 0x%0h with no request pending", rsp_data);
            end else begin
                if (!vprev) chk("rsp_rise_cyc", cyc, sb[rd_idx].rise);
                chk("rsp_data", rsp_data, sb[rd_idx].data);
                if (rsp_ready) rd_idx++;
            end
        end
        vprev = rsp_valid;
    end

    // Called at a negedge; returns at a negedge with the accept edge number in e
    task automatic send(input bit ir, input int len, input logic [63:0] d,
                        input logic [63:0] exp_d, input int bits, input bit push, output int e);
        int t = 0;
        req_is_ir = ir;
        req_len   = LW'(len);
        req_data  = d;
        req_valid = 1'b1;
        while (!req_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        e = cyc + 1;
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", t);
            req_valid = 1'b0;
            return;
        end
        if (push) sb.push_back('{data: exp_d, rise: (e + 1 + bits * 2 * ClkDiv)});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (rd_idx < sb.size() && t < 3000) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (rd_idx < sb.size()) begin
            errors++;
            $display("FAIL %s: response timeout, %0d pending", name, sb.size() - rd_idx);
        end
        @(negedge clk);
    endtask

    task automatic wait_init(input string name, input int r0);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready && t < 100);
        chk(name, cyc - r0, 25);
        chk({name, "_tap_rti"}, ts == RTI, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tck"}, tck, 1'b0);
        chk({tag, "_tms"}, tms, 1'b1);
        chk({tag, "_tdi"}, tdi, 1'b0);
        chk({tag, "_trst"}, trst_n, 1'b0);
        chk({tag, "_req_ready"}, req_ready, 1'b0);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_data"}, rsp_data, 64'h0);
    endtask

    initial begin
        int e, e2, s, r0, h, sh0, t;
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("reset");

        // Reset release and INIT walk to Run-Test/Idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r0 = cyc;
        s = pulses;
        @(negedge clk);
        chk("init_trst_1clk", trst_n, 1'b1);
        wait_init("init_ready_cyc", r0);
        chk("init_pulses", pulses - s, 6);
        chk("init_tms_seq", tms_hist[5:0], 6'b111110);

        // DR scan, len 8
        dr_cap = 8'h3C;
        s = pulses;
        send(1'b0, 8, 64'hA5, 64'h3C, 13, 1'b1, e);
        wait_done("dr8");
        chk("dr8_pulses", pulses - s, 13);
        chk("dr8_tms_seq", tms_hist[12:0], 13'h1006);
        chk("dr8_first_rise", rise_at[s], e + 1 + ClkDiv);
        chk("dr8_tap_dr", dr_reg, 8'hA5);
        chk("dr8_tap_rti", ts == RTI, 1'b1);

        // IR scan, len 5
        s = pulses;
        send(1'b1, 5, 64'h01, 64'h01, 11, 1'b1, e);
        wait_done("ir5");
        chk("ir5_pulses", pulses - s, 11);
        chk("ir5_tms_seq", tms_hist[10:0], 11'h606);
        chk("ir5_tap_ir", ir_reg, 5'h01);

        // Backpressure with a second request waiting
        dr_cap = 8'h69;
        rsp_ready = 1'b0;
        send(1'b0, 8, 64'h5A, 64'h69, 13, 1'b1, e);
        t = 0;
        while (!rsp_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        req_is_ir = 1'b0;
        req_len   = LW'(8);
        req_data  = 64'hC3;
        req_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("bp_req_ready_low", req_ready, 1'b0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        h = cyc + 1;
        @(negedge clk);
        send(1'b0, 8, 64'hC3, 64'h69, 13, 1'b1, e2);
        chk("bp_accept_cyc", e2, h + 1);
        wait_done("bp");
        chk("bp_tap_dr", dr_reg, 8'hC3);

        // len 0: no TCK, response the clk after acceptance, data cleared
        s = pulses;
        send(1'b0, 0, 64'hFFFF, 64'h0, 0, 1'b1, e);
        wait_done("len0");
        chk("len0_pulses", pulses - s, 0);

        // Oversized length saturates to MaxLen shifts
        dr_cap = 8'h3C;
        s = pulses;
        sh0 = dr_shifts;
        send(1'b0, MaxLen + 5, '1, 64'hFFFF_FFFF_FFFF_FF3C, MaxLen + 5, 1'b1, e);
        wait_done("lenmax");
        chk("lenmax_pulses", pulses - s, MaxLen + 5);
        chk("lenmax_shifts", dr_shifts - sh0, MaxLen);
        chk("lenmax_tap_dr", dr_reg, 8'hFF);

        // Reset during shift bit 3 (7th TCK pulse) of an 8-bit DR scan
        s = pulses;
        send(1'b0, 8, 64'hA5, 64'h0, 13, 1'b0, e);
        t = 0;
        while (pulses < s + 7 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("midrst_reached_bit3", pulses - s, 7);
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r0 = cyc;
        wait_init("reinit_ready_cyc", r0);
        dr_cap = 8'h3C;
        send(1'b0, 8, 64'hA5, 64'h3C, 13, 1'b1, e);
        wait_done("post_rst");
        chk("post_rst_tap_dr", dr_reg, 8'hA5);

        repeat (5) @(negedge clk);
        chk("sb_drained", rd_idx, sb.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
